// File: rtl/fifo_ctrl.sv
// Control path for an 8-entry register FIFO: head/tail pointers, occupancy count,
// write strobe, and one-cycle registered ack/error status for each side.
module fifo_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic       we,
  output logic [2:0] wr_addr,
  output logic [2:0] rd_addr,
  output logic       full,
  output logic       empty,
  output logic [3:0] data_count,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       rd_ack,
  output logic       rd_err
);

  // state       | meaning (operation performed in the previous cycle)
  // ST_INIT     | held in reset
  // ST_NO_OP    | no request accepted or rejected
  // ST_WRITE    | write accepted only
  // ST_READ     | read accepted only
  // ST_WR_RD    | write and read accepted together
  // ST_WR_ERROR | write rejected (full), no read accepted
  // ST_RD_ERROR | read rejected (empty), no write accepted
  typedef enum logic [2:0] {
    ST_INIT,
    ST_NO_OP,
    ST_WRITE,
    ST_READ,
    ST_WR_RD,
    ST_WR_ERROR,
    ST_RD_ERROR
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] head_q, head_d;
  logic [2:0] tail_q, tail_d;
  logic [3:0] count_q, count_d;
  logic       wr_err_q, wr_err_d;
  logic       rd_err_q, rd_err_d;
  logic       wa, ra;

  assign full  = (count_q == 4'd8);
  assign empty = (count_q == 4'd0);
  assign wa    = wr_en & ~full & reset_n;
  assign ra    = rd_en & ~empty & reset_n;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    state_d  = ST_NO_OP;
    wr_err_d = wr_en & full;
    rd_err_d = rd_en & empty;
    if (wa) tail_d = tail_q + 3'd1;
    if (ra) head_d = head_q + 3'd1;
    case ({wa, ra})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (wa && ra)                  state_d = ST_WR_RD;
    else if (wa)                   state_d = ST_WRITE;
    else if (ra)                   state_d = ST_READ;
    else if (wr_en && full)        state_d = ST_WR_ERROR;
    else if (rd_en && empty)       state_d = ST_RD_ERROR;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      head_q   <= 3'd0;
      tail_q   <= 3'd0;
      count_q  <= 4'd0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Errors live in their own flops so they can coexist with an accept on the other side.
  assign we         = wa;
  assign wr_addr    = tail_q;
  assign rd_addr    = head_q;
  assign data_count = count_q;
  assign wr_ack     = (state_q == ST_WRITE) || (state_q == ST_WR_RD);
  assign rd_ack     = (state_q == ST_READ)  || (state_q == ST_WR_RD);
  assign wr_err     = wr_err_q;
  assign rd_err     = rd_err_q;

endmodule
